// File: rtl/al_lut4_cfg_writer.sv
// -----------------------------------------------------------------------------
// al_lut4_cfg_writer
//
// Receives LUT4 configuration frames over a byte stream and writes 16-bit INIT
// words into a bank of NUM_LUTS configuration slots. A combinational lookup
// port evaluates any stored slot with LUT4 INIT bit ordering (a = index LSB).
//
// Frame: HDR_BYTE, ADDR, INIT[7:0], INIT[15:8]. After the last byte the FSM
// spends one ce-enabled cycle in COMMIT, where the slot is written (good
// address) or an error is flagged (address >= NUM_LUTS).
//
// Ports:
//   clk        clock, all state updates on posedge
//   sr         asynchronous active-high reset
//   ce         clock enable; 0 freezes all state and masks the pulses
//   in_data    configuration byte
//   in_valid   in_data valid
//   in_ready   block can accept a byte (ce && state != COMMIT)
//   wr_done    one-cycle pulse: slot written
//   err        one-cycle pulse: bad header byte or bad address
//   cfg_count  successful write count, saturating at 255
//   lk_sel     slot selected for lookup
//   a,b,c,d    lookup index bits, a = bit 0
//   o          lookup result, 0 when lk_sel >= NUM_LUTS
// -----------------------------------------------------------------------------
module al_lut4_cfg_writer #(
    parameter int          NUM_LUTS     = 8,
    parameter logic [15:0] DEFAULT_INIT = 16'h0000,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       sr,
    input  logic       ce,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       wr_done,
    output logic       err,
    output logic [7:0] cfg_count,
    input  logic [7:0] lk_sel,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       o
);

    localparam int         AW         = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam logic [8:0] NUM_LUTS_W = 9'(NUM_LUTS);

    typedef enum logic [2:0] {
        ST_HDR    = 3'd0,
        ST_ADR    = 3'd1,
        ST_LO     = 3'd2,
        ST_HI     = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [AW-1:0] addr_r;
    logic          bad_r;
    logic [7:0]    lo_r;
    logic [7:0]    hi_r;
    logic          wr_done_r;
    logic          err_r;
    logic [7:0]    cfg_count_r;
    logic [15:0]   slot_r [NUM_LUTS];

    logic          in_ready_s;
    logic          accept_s;
    logic          hdr_bad_s;
    logic          commit_s;
    logic [15:0]   lut_word_s;

    assign in_ready_s = ce && (state_r != ST_COMMIT);
    assign accept_s   = in_valid && in_ready_s;

    // Next-state decode; also flags a rejected header and the commit cycle.
    always_comb begin
        state_nx_s = state_r;
        hdr_bad_s  = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            ST_HDR: begin
                if (accept_s) begin
                    if (in_data == HDR_BYTE) begin
                        state_nx_s = ST_ADR;
                    end else begin
                        hdr_bad_s  = 1'b1;
                        state_nx_s = ST_HDR;
                    end
                end else begin
                    state_nx_s = ST_HDR;
                end
            end
            ST_ADR: begin
                if (accept_s) state_nx_s = ST_LO;
                else          state_nx_s = ST_ADR;
            end
            ST_LO: begin
                if (accept_s) state_nx_s = ST_HI;
                else          state_nx_s = ST_LO;
            end
            ST_HI: begin
                if (accept_s) state_nx_s = ST_COMMIT;
                else          state_nx_s = ST_HI;
            end
            ST_COMMIT: begin
                // Closes on the next ce=1 edge regardless of in_valid.
                commit_s   = ce;
                state_nx_s = ST_HDR;
            end
            default: begin
                state_nx_s = ST_HDR;
            end
        endcase
    end

    // FSM state register, frozen while ce=0.
    always_ff @(posedge clk or posedge sr) begin
        if (sr) begin
            state_r <= ST_HDR;
        end else if (ce) begin
            state_r <= state_nx_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Frame field latches, result pulses and the saturating write counter.
    always_ff @(posedge clk or posedge sr) begin
        if (sr) begin
            addr_r      <= '0;
            bad_r       <= 1'b0;
            lo_r        <= 8'h00;
            hi_r        <= 8'h00;
            wr_done_r   <= 1'b0;
            err_r       <= 1'b0;
            cfg_count_r <= 8'h00;
        end else if (ce) begin
            // Pulses are recomputed every enabled edge, so each lasts one cycle.
            wr_done_r <= commit_s && !bad_r;
            err_r     <= hdr_bad_s || (commit_s && bad_r);
            if (accept_s && (state_r == ST_ADR)) begin
                addr_r <= in_data[AW-1:0];
                bad_r  <= ({1'b0, in_data} >= NUM_LUTS_W);
            end else if (commit_s) begin
                bad_r <= 1'b0;
            end else begin
                bad_r <= bad_r;
            end
            if (accept_s && (state_r == ST_LO)) lo_r <= in_data;
            else                                lo_r <= lo_r;
            if (accept_s && (state_r == ST_HI)) hi_r <= in_data;
            else                                hi_r <= hi_r;
            if (commit_s && !bad_r && (cfg_count_r != 8'hFF)) begin
                cfg_count_r <= cfg_count_r + 8'd1;
            end else begin
                cfg_count_r <= cfg_count_r;
            end
        end else begin
            wr_done_r   <= wr_done_r;
            err_r       <= err_r;
            cfg_count_r <= cfg_count_r;
        end
    end

    // Configuration slot bank, written only on a good-address commit.
    always_ff @(posedge clk or posedge sr) begin
        if (sr) begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                slot_r[i] <= DEFAULT_INIT;
            end
        end else if (ce && commit_s && !bad_r) begin
            slot_r[addr_r] <= {hi_r, lo_r};
        end else begin
            slot_r <= slot_r;
        end
    end

    // Lookup word select; out-of-range selects read as all zeros.
    always_comb begin
        lut_word_s = 16'h0000;
        if ({1'b0, lk_sel} < NUM_LUTS_W) begin
            lut_word_s = slot_r[lk_sel[AW-1:0]];
        end else begin
            lut_word_s = 16'h0000;
        end
    end

    assign o         = lut_word_s[{d, c, b, a}];
    assign in_ready  = in_ready_s;
    // A pulse held during ce=0 is masked, then shown in the next enabled cycle.
    assign wr_done   = wr_done_r && ce;
    assign err       = err_r && ce;
    assign cfg_count = cfg_count_r;

endmodule

// File: tb/tb_al_lut4_cfg_writer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for al_lut4_cfg_writer. Expected wr_done/err pulses (with
// the cfg_count value that must accompany them) are queued when a frame is
// driven and popped by a monitor when the DUT pulses. Lookups are compared
// against a bench-side copy of the slot bank.
// -----------------------------------------------------------------------------
module tb_al_lut4_cfg_writer;

    localparam int NUM = 8;

    logic       clk = 1'b0;
    logic       sr;
    logic       ce;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       wr_done;
    logic       err;
    logic [7:0] cfg_count;
    logic [7:0] lk_sel;
    logic       a, b, c, d;
    logic       o;

    typedef struct packed {
        logic       is_err;
        logic [7:0] cnt;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] model [NUM];
    int          cnt_m  = 0;
    int          errors = 0;
    int          checks = 0;

    al_lut4_cfg_writer #(
        .NUM_LUTS     (NUM),
        .DEFAULT_INIT (16'h0000),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .clk       (clk),
        .sr        (sr),
        .ce        (ce),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_done   (wr_done),
        .err       (err),
        .cfg_count (cfg_count),
        .lk_sel    (lk_sel),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .o         (o)
    );

    always #5 clk = ~clk;

    // Pulse monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_done === 1'b1 || err === 1'b1) begin
            ev_t e;
            checks++;
            if (wr_done === 1'b1 && err === 1'b1) begin
                errors++;
                $display("FAIL pulse_overlap wr_done=%b err=%b expected never both", wr_done, err);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse wr_done=%b err=%b at %0t expected none", wr_done, err, $time);
            end else begin
                e = exp_q.pop_front();
                if (err !== e.is_err || cfg_count !== e.cnt) begin
                    errors++;
                    $display("FAIL pulse err=%b cfg_count=%0d expected err=%b cfg_count=%0d",
                             err, cfg_count, e.is_err, e.cnt);
                end
            end
        end
    end

    task automatic sync();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Presents one byte; returns #1 after the edge that accepts it.
    task automatic send_byte(input logic [7:0] v);
        int n;
        n        = 0;
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout byte=%h in_ready=%b expected 1", v, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Records the outcome a frame must produce and updates the slot model.
    task automatic push_frame(input logic [7:0] ad, input logic [7:0] lo, input logic [7:0] hi);
        if (ad < NUM) begin
            model[ad] = {hi, lo};
            cnt_m     = (cnt_m >= 255) ? 255 : cnt_m + 1;
            exp_q.push_back({1'b0, 8'(cnt_m)});
        end else begin
            exp_q.push_back({1'b1, 8'(cnt_m)});
        end
    endtask

    task automatic send_frame(input logic [7:0] ad, input logic [7:0] lo, input logic [7:0] hi);
        push_frame(ad, lo, hi);
        send_byte(8'hA5);
        send_byte(ad);
        send_byte(lo);
        send_byte(hi);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending_pulses=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_lut(input logic [7:0] sel);
        logic exp_o;
        lk_sel = sel;
        for (int i = 0; i < 16; i++) begin
            {d, c, b, a} = 4'(i);
            #1;
            exp_o = (sel < NUM) ? model[sel[2:0]][i] : 1'b0;
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("FAIL lut sel=%0d idx=%0d o=%b expected %b", sel, i, o, exp_o);
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || wr_done !== 1'b0 || err !== 1'b0 || cfg_count !== 8'(cnt_m)) begin
            errors++;
            $display("FAIL %s in_ready=%b wr_done=%b err=%b cfg_count=%0d expected 1 0 0 %0d",
                     name, in_ready, wr_done, err, cfg_count, cnt_m);
        end
    endtask

    task automatic test_reset();
        sr = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        lk_sel = 8'h00; {d, c, b, a} = 4'h0;
        for (int i = 0; i < NUM; i++) model[i] = 16'h0000;
        cnt_m = 0;
        repeat (3) @(posedge clk);
        #1;
        sr = 1'b0;
        check_idle("reset_outputs");
        for (int s = 0; s < NUM; s++) check_lut(8'(s));
    endtask

    task automatic test_frame();
        sync();
        send_frame(8'h03, 8'hCA, 8'hFE);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_ready in_ready=%b expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_commit_ready in_ready=%b expected 1", in_ready);
        end
        drain();
        check_lut(8'h03);
        lk_sel = 8'h03; {d, c, b, a} = 4'b0001; #1;
        checks++;
        if (o !== 1'b1 || cfg_count !== 8'd1) begin
            errors++;
            $display("FAIL frame_a5_03 o=%b cfg_count=%0d expected 1 1", o, cfg_count);
        end
    endtask

    task automatic test_bad_header();
        sync();
        exp_q.push_back({1'b1, 8'(cnt_m)});
        send_byte(8'h5A);
        send_frame(8'h01, 8'hFF, 8'hFF);
        drain();
        check_lut(8'h01);
        check_idle("bad_header_count");
    endtask

    task automatic test_bad_addr();
        sync();
        send_frame(8'h09, 8'h12, 8'h34);
        drain();
        check_idle("bad_addr_count");
        check_lut(8'h09);
        for (int s = 0; s < NUM; s++) check_lut(8'(s));
    endtask

    task automatic test_mid_frame_reset();
        sync();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h55);
        in_valid = 1'b0;
        sr = 1'b1;
        @(negedge clk);
        sr = 1'b0;
        for (int i = 0; i < NUM; i++) model[i] = 16'h0000;
        cnt_m = 0;
        check_idle("mid_frame_reset");
        check_lut(8'h01);
        check_lut(8'h03);
        sync();
        send_frame(8'h02, 8'hAA, 8'hAA);
        drain();
        check_lut(8'h02);
        check_idle("after_reset_frame");
    endtask

    task automatic test_ce_stall();
        sync();
        push_frame(8'h04, 8'h34, 8'h12);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h34);
        send_byte(8'h12);
        ce = 1'b0;
        lk_sel = 8'h04; {d, c, b, a} = 4'd2;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || wr_done !== 1'b0 || o !== 1'b0) begin
                errors++;
                $display("FAIL ce_low cycle=%0d in_ready=%b wr_done=%b o=%b expected 0 0 0",
                         i, in_ready, wr_done, o);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_done !== 1'b0) begin
            errors++;
            $display("FAIL ce_back_commit in_ready=%b wr_done=%b expected 0 0", in_ready, wr_done);
        end
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b1 || o !== 1'b1) begin
            errors++;
            $display("FAIL deferred_pulse wr_done=%b o=%b expected 1 1", wr_done, o);
        end
        drain();
        check_lut(8'h04);
    endtask

    task automatic test_back_to_back();
        time t0;
        time t1;
        sync();
        push_frame(8'h06, 8'h0F, 8'hF0);
        push_frame(8'h07, 8'h3C, 8'hC3);
        send_byte(8'hA5);
        t0 = $time;
        send_byte(8'h06); send_byte(8'h0F); send_byte(8'hF0);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h3C); send_byte(8'hC3);
        t1 = $time;
        in_valid = 1'b0;
        checks++;
        if (t1 - t0 != 80) begin
            errors++;
            $display("FAIL back_to_back span=%0t expected 80", t1 - t0);
        end
        drain();
        check_lut(8'h06);
        check_lut(8'h07);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            sync();
            send_frame(8'h05, 8'(i), 8'(~i));
        end
        drain();
        checks++;
        if (cfg_count !== 8'd255 || cnt_m != 255) begin
            errors++;
            $display("FAIL saturation cfg_count=%0d expected 255", cfg_count);
        end
        check_lut(8'h05);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_bad_header();
        test_bad_addr();
        test_mid_frame_reset();
        test_ce_stall();
        test_back_to_back();
        test_saturation();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/al_lut4_cfg_writer.md
Name: al_lut4_cfg_writer

Overview:
Write-side counterpart to the LUT4 simulation model. The LUT4 model only reads a static INIT; this block receives configuration frames over a byte stream, decodes them, and writes 16-bit INIT words into a bank of NUM_LUTS LUT4 configuration registers. It also exposes a combinational lookup port that evaluates any stored LUT with the same bit ordering as the LUT4 model, so benches can check configurations end to end.

Parameters:
NUM_LUTS, 8, number of LUT4 configuration slots (1..256)
DEFAULT_INIT, 16'h0000, INIT value loaded into every slot on reset
HDR_BYTE, 8'hA5, required frame header byte

Ports:
clk  input  1  clock; all state updates on posedge
sr  input  1  asynchronous active-high reset
ce  input  1  clock enable; 0 freezes FSM, memory and counters
in_data  input  8  configuration byte
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte
wr_done  output  1  one-cycle pulse: slot written
err  output  1  one-cycle pulse: bad header or bad address
cfg_count  output  8  count of successful writes, saturating
lk_sel  input  8  slot selected for lookup
a  input  1  lookup input, INIT index bit 0
b  input  1  lookup input, INIT index bit 1
c  input  1  lookup input, INIT index bit 2
d  input  1  lookup input, INIT index bit 3
o  output  1  lookup result

Behaviour:
- Reset (sr=1, async): FSM=HDR; every slot=DEFAULT_INIT; wr_done=0; err=0; cfg_count=0; address, LO and bad-address latches cleared. A partial frame in progress is discarded. in_ready=ce after reset deasserts.
- Frame format: HDR_BYTE, ADDR, INIT[7:0], INIT[15:8], sent in that order.
- Handshake: a byte is accepted on a posedge where in_valid && in_ready. in_data must be held while in_valid=1 and in_ready=0.
- in_ready = ce && (state != COMMIT).
- FSM states: HDR, ADR, LO, HI, COMMIT. Transitions happen only on accepted bytes, except COMMIT.
  - HDR: if the accepted byte equals HDR_BYTE, go to ADR. Otherwise err pulses the next cycle and the FSM stays in HDR.
  - ADR: latch the address. Set the bad flag if the byte >= NUM_LUTS. Go to LO.
  - LO: latch the byte as INIT[7:0]. Go to HI.
  - HI: latch the byte as INIT[15:8]. Go to COMMIT.
  - COMMIT: lasts exactly one ce-enabled cycle and accepts no byte. On the closing edge:
    - if the address is good: slot[addr] <= {hi, lo}; wr_done <= 1; cfg_count increments, saturating at 255.
    - if the bad flag is set: no write; err <= 1.
    - in both cases the bad flag clears and the FSM goes to HDR.
- Latency: the HI byte is accepted on edge E0 and COMMIT closes on edge E1 (the next ce=1 edge). From the cycle after E1:
  - wr_done=1 (or err=1) for one cycle;
  - the lookup reflects the new INIT in that same cycle.
- ce=0: all registers hold, in_ready=0, and wr_done/err are forced to 0. A pulse due is deferred, not lost: it appears after the next ce=1 edge.
- Pulses: wr_done and err are registered and never asserted together. Each is cleared on the edge after it is raised (when ce=1).
- Lookup (combinational): o = slot[lk_sel][{d,c,b,a}].
  - If lk_sel >= NUM_LUTS, o=0.
  - Ordering matches LUT4 INIT: a is the LSB of the index.
- Back-to-back frames: a new HDR byte may be accepted on the first cycle after COMMIT closes. Throughput is one frame per 5 cycles.
- A simultaneous write to slot[addr] and lookup of that slot returns the old value until the closing edge.

Test Plan:
- Reset, then sweep lk_sel=0..7 and all a..d -> o=0 everywhere (DEFAULT_INIT=0); in_ready=1; cfg_count=0.
- Send frame A5,03,CA,FE with in_valid held high -> in_ready low for exactly one cycle; wr_done pulses once. Then lk_sel=3:
  - {d,c,b,a}=0000 -> o=0 (bit0 of 0xFECA=0);
  - 0001 -> o=1;
  - 1111 -> o=1;
  - cfg_count=1.
- Send byte 5A then frame A5,01,FF,FF -> err pulses once for 5A, then wr_done once; slot1=FFFF; cfg_count=1 more.
- Send frame A5,09,12,34 (NUM_LUTS=8) -> err pulses after COMMIT; no slot changes; cfg_count unchanged; lk_sel=9 gives o=0.
- Assert sr after accepting A5,02,55 -> all outputs return to reset values. The next frame A5,02,AA,AA writes slot2=AAAA, and o at {d,c,b,a}=0001 is 1.
- Drop ce for 3 cycles during COMMIT and toggle in_valid randomly -> no bytes accepted; wr_done appears only after ce returns. 256 valid frames -> cfg_count saturates at 255.
